// File: rtl/display_scan_multimode.sv
// Multiplexed common-anode 7-segment scanner showing a captured result in binary,
// hex or unsigned decimal, with leading-zero blanking and overflow dashes.
module display_scan_multimode #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          HOLD       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     resultado,
  input  logic                  done,
  input  logic [1:0]            mode,
  output logic [6:0]            Sseg,
  output logic [NUM_DIGITS-1:0] anodos,
  output logic                  busy
);

  localparam int unsigned HEX_D  = (DATA_W + 3) / 4;
  localparam int unsigned BCD_D  = (DATA_W * 3) / 10 + 1;
  localparam int unsigned NUM_A  = (HEX_D > BCD_D) ? HEX_D : BCD_D;
  localparam int unsigned MAX_D  = (NUM_A > NUM_DIGITS) ? NUM_A : NUM_DIGITS;
  localparam int unsigned NIB_W  = 4 * MAX_D;
  localparam int unsigned BCD_W  = 4 * BCD_D;
  localparam int unsigned MAX_B  = (DATA_W > NUM_DIGITS) ? DATA_W : NUM_DIGITS;
  localparam int unsigned PW     = $clog2(SCAN_DIV);
  localparam int unsigned DW     = $clog2(NUM_DIGITS);
  localparam int unsigned CW     = $clog2(DATA_W + 1);

  localparam logic [6:0] G_DASH  = 7'b1111110;
  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [1:0] M_BIN   = 2'b00;
  localparam logic [1:0] M_HEX   = 2'b01;
  localparam logic [1:0] M_DEC   = 2'b10;

  typedef logic [NUM_DIGITS-1:0][6:0] buf_t;
  localparam buf_t BUF_BLANK = '1;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b1100000;
      4'hC:    glyph = 7'b0110001;
      4'hD:    glyph = 7'b1000010;
      4'hE:    glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  // Nibble-per-digit encoder shared by hex and BCD: blanking plus overflow dashes.
  function automatic buf_t enc_num(input logic [NIB_W-1:0] d);
    buf_t b;
    logic ovf;
    logic seen;
    ovf = 1'b0;
    for (int i = int'(NUM_DIGITS); i < int'(MAX_D); i++) ovf |= (d[4*i +: 4] != 4'h0);
    seen = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      seen |= (d[4*i +: 4] != 4'h0) || (i == 0);
      b[i] = ovf ? G_DASH : (seen ? glyph(d[4*i +: 4]) : G_BLANK);
    end
    return b;
  endfunction

  function automatic buf_t enc_bin(input logic [MAX_B-1:0] v);
    buf_t b;
    logic ovf;
    ovf = 1'b0;
    for (int i = int'(NUM_DIGITS); i < int'(MAX_B); i++) ovf |= v[i];
    for (int i = 0; i < int'(NUM_DIGITS); i++)
      b[i] = ovf ? G_DASH : ((i < int'(DATA_W)) ? glyph({3'b000, v[i]}) : G_BLANK);
    return b;
  endfunction

  logic [PW-1:0]     pre;
  logic [DW-1:0]     sptr;
  logic              done_q;
  logic              rise;
  logic [DATA_W-1:0] cap_val;
  logic [1:0]        cap_mode;
  logic              pend;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_next;
  buf_t              dbuf;

  always_comb rise = done & ~done_q;

  // One double-dabble step: add-3 correction then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(BCD_D); i++)
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    bcd_next = (bcd_adj << 1) | BCD_W'(shreg[DATA_W-1]);
  end

  // Scan: sptr names the digit loaded at the next terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre    <= '0;
      sptr   <= '0;
      Sseg   <= G_BLANK;
      anodos <= '1;
    end else if (pre == PW'(SCAN_DIV - 1)) begin
      pre    <= '0;
      sptr   <= (sptr == DW'(NUM_DIGITS - 1)) ? '0 : sptr + DW'(1);
      anodos <= ~(NUM_DIGITS'(1) << sptr);
      Sseg   <= dbuf[sptr];
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Capture, encode and sequential BCD conversion; a new capture freezes any running
  // conversion so a stale value can never land in the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      cap_val  <= '0;
      cap_mode <= '0;
      pend     <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      shreg    <= '0;
      bcd      <= '0;
      dbuf     <= BUF_BLANK;
    end else begin
      done_q <= done;
      if (rise) begin
        cap_val  <= resultado;
        cap_mode <= mode;
        pend     <= 1'b1;
      end else if (!done_q && !HOLD) begin
        pend <= 1'b0;
        busy <= 1'b0;
        dbuf <= BUF_BLANK;
      end else if (pend) begin
        pend <= 1'b0;
        case (cap_mode)
          M_DEC: begin
            busy  <= 1'b1;
            shreg <= cap_val;
            bcd   <= '0;
            cnt   <= '0;
          end
          M_BIN: begin
            busy <= 1'b0;
            dbuf <= enc_bin(MAX_B'(cap_val));
          end
          M_HEX: begin
            busy <= 1'b0;
            dbuf <= enc_num(NIB_W'(cap_val));
          end
          default: begin
            busy <= 1'b0;
            dbuf <= BUF_BLANK;
          end
        endcase
      end else if (busy) begin
        shreg <= shreg << 1;
        bcd   <= bcd_next;
        cnt   <= cnt + CW'(1);
        if (cnt == CW'(DATA_W - 1)) begin
          busy <= 1'b0;
          dbuf <= enc_num(NIB_W'(bcd_next));
        end
      end
    end
  end

endmodule
